// File: rtl/adrv9001_pkg.sv
// ADRV9001 TDD sequencer shared definitions.
// Holds the per-channel FSM state encoding used by the channel sequencer.
package adrv9001_pkg;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] EN_WAIT  = 3'd1;
    localparam logic [2:0] ACTIVE   = 3'd2;
    localparam logic [2:0] DIS_WAIT = 3'd3;
    localparam logic [2:0] SSI_WAIT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = IDLE,
        S_EN_WAIT  = EN_WAIT,
        S_ACTIVE   = ACTIVE,
        S_DIS_WAIT = DIS_WAIT,
        S_SSI_WAIT = SSI_WAIT
    } tdd_state_t;

endpackage

// File: rtl/adrv9001_tdd_ch.sv
// ADRV9001 single-channel TDD enable sequencer (FSM + delay down-counter).
// Ports: clk, rst (async high), tdd_en request, three delay counts in,
//        registered enable / ssi_en / busy / done (1-cycle) out.
module adrv9001_tdd_ch
    import adrv9001_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tdd_en,
    input  logic [CNT_W-1:0] ssi_enable_cnt,
    input  logic [CNT_W-1:0] disable_cnt,
    input  logic [CNT_W-1:0] ssi_disable_cnt,
    output logic             enable,
    output logic             ssi_en,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    tdd_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // Outputs are assigned together with the next state so every output
    // is a flop that reflects the state being entered. A tdd_en change is
    // always checked before counter expiry so the request wins ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            enable <= 1'b0;
            ssi_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (tdd_en) begin
                        state  <= S_EN_WAIT;
                        cnt    <= ssi_enable_cnt;
                        enable <= 1'b1;
                        ssi_en <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                S_EN_WAIT: begin
                    if (!tdd_en) begin
                        state  <= S_IDLE;
                        enable <= 1'b0;
                        ssi_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (cnt_zero) begin
                        state  <= S_ACTIVE;
                        ssi_en <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                S_ACTIVE: begin
                    if (!tdd_en) begin
                        state <= S_DIS_WAIT;
                        cnt   <= disable_cnt;
                    end
                end
                S_DIS_WAIT: begin
                    if (tdd_en) begin
                        state <= S_ACTIVE;
                    end else if (cnt_zero) begin
                        state  <= S_SSI_WAIT;
                        cnt    <= ssi_disable_cnt;
                        enable <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                S_SSI_WAIT: begin
                    if (tdd_en) begin
                        state  <= S_EN_WAIT;
                        cnt    <= ssi_enable_cnt;
                        enable <= 1'b1;
                        ssi_en <= 1'b0;
                    end else if (cnt_zero) begin
                        state  <= S_IDLE;
                        ssi_en <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    cnt    <= '0;
                    enable <= 1'b0;
                    ssi_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/adrv9001_tdd_seq.sv
// ADRV9001 multi-channel TDD sequencer: NUM_CH independent channel FSMs.
// Ports: clk, rst (async high), tdd_en[NUM_CH], packed per-channel counts
//        (channel k at [k*CNT_W +: CNT_W]), enable/ssi_en/busy/done[NUM_CH].
module adrv9001_tdd_seq
    import adrv9001_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       tdd_en,
    input  logic [NUM_CH*CNT_W-1:0] ssi_enable_cnt,
    input  logic [NUM_CH*CNT_W-1:0] disable_cnt,
    input  logic [NUM_CH*CNT_W-1:0] ssi_disable_cnt,
    output logic [NUM_CH-1:0]       enable,
    output logic [NUM_CH-1:0]       ssi_en,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        adrv9001_tdd_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk             (clk),
            .rst             (rst),
            .tdd_en          (tdd_en[g]),
            .ssi_enable_cnt  (ssi_enable_cnt[g*CNT_W +: CNT_W]),
            .disable_cnt     (disable_cnt[g*CNT_W +: CNT_W]),
            .ssi_disable_cnt (ssi_disable_cnt[g*CNT_W +: CNT_W]),
            .enable          (enable[g]),
            .ssi_en          (ssi_en[g]),
            .busy            (busy[g]),
            .done            (done[g])
        );
    end

endmodule

// File: doc/adrv9001_tdd_seq.md
ADRV9001_TDD_SEQ -- requirements
Module: adrv9001_tdd_seq

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent RF channels sequenced (range 1..8).
REQ-002 Parameter CNT_W, default 32: width of every per-channel delay count (range 8..32).
REQ-003 Single clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock for all logic.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 tdd_en  in  NUM_CH  per-channel enable request, already synchronous to clk.
REQ-007 ssi_enable_cnt  in  NUM_CH*CNT_W  per-channel delay from enable rise to ssi_en rise; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-008 disable_cnt  in  NUM_CH*CNT_W  per-channel delay from tdd_en fall to enable fall; same packing.
REQ-009 ssi_disable_cnt  in  NUM_CH*CNT_W  per-channel delay from enable fall to ssi_en fall; same packing.
REQ-010 enable  out  NUM_CH  device enable pin drive (rx/tx_en).
REQ-011 ssi_en  out  NUM_CH  SSI datapath enable.
REQ-012 busy  out  NUM_CH  1 whenever the channel state is not IDLE.
REQ-013 done  out  NUM_CH  one-cycle pulse on the SSI_WAIT->IDLE transition.

Function
REQ-014 Each channel SHALL run an independent FSM: IDLE, EN_WAIT, ACTIVE, DIS_WAIT, SSI_WAIT; all outputs registered.
REQ-015 Outputs per state: IDLE en=0 ssi=0; EN_WAIT en=1 ssi=0; ACTIVE en=1 ssi=1; DIS_WAIT en=1 ssi=1; SSI_WAIT en=0 ssi=1.
REQ-016 The down-counter SHALL load the state's count on state entry; the state exits when the counter is 0, otherwise it decrements; a wait state therefore lasts count+1 cycles (count=0 -> 1 cycle).
REQ-017 IDLE->EN_WAIT when tdd_en=1 (load ssi_enable_cnt); enable rises the cycle after tdd_en is sampled high.
REQ-018 EN_WAIT->ACTIVE at counter 0; EN_WAIT->IDLE immediately if tdd_en falls (abort, no done pulse, ssi_en never asserted).
REQ-019 ACTIVE->DIS_WAIT when tdd_en=0 (load disable_cnt).
REQ-020 DIS_WAIT->SSI_WAIT at counter 0 (load ssi_disable_cnt); DIS_WAIT->ACTIVE if tdd_en re-asserts (counter discarded).
REQ-021 SSI_WAIT->IDLE at counter 0 with done=1 for that cycle; if tdd_en re-asserts in SSI_WAIT, go to EN_WAIT (load ssi_enable_cnt), no done pulse.
REQ-022 Count inputs SHALL be sampled only at load; changes mid-count do not affect the running count.
REQ-023 When counter reaches 0 and tdd_en changes in the same cycle, the tdd_en-driven transition (REQ-018/020/021) SHALL take priority.
REQ-024 Counter SHALL never wrap: all-ones count yields exactly 2^CNT_W cycles; no underflow below 0.
REQ-025 Channels SHALL not interact; simultaneous events on different channels are handled in the same cycle.

Reset
REQ-026 While rst=1 every channel SHALL be IDLE, counters 0, enable=0, ssi_en=0, busy=0, done=0, asynchronously.
REQ-027 Reset asserted mid-sequence SHALL drop enable and ssi_en in the same cycle regardless of state; after release, a held-high tdd_en restarts from IDLE->EN_WAIT on the first clock edge.

Structure
REQ-028 State encoding (3-bit localparams IDLE..SSI_WAIT) SHALL live in shared package adrv9001_pkg.
REQ-029 Per-channel FSM plus counter SHALL be sub-module adrv9001_tdd_ch, generated NUM_CH times in adrv9001_tdd_seq.

Verification
REQ-030 Ch0 ssi_enable_cnt=3, disable_cnt=2, ssi_disable_cnt=4, tdd_en high 20 cycles -> enable high cycle 1, ssi_en high cycle 5; after fall, enable low 3 cycles later, ssi_en low 5 cycles after that, done pulse once.
REQ-031 All counts 0, tdd_en one-cycle pulse -> EN_WAIT->IDLE abort: enable high 1 cycle, ssi_en never high, no done.
REQ-032 tdd_en drops then re-asserts during DIS_WAIT (disable_cnt=10, re-assert after 4) -> returns to ACTIVE, enable and ssi_en stay high continuously.
REQ-033 Re-assert during SSI_WAIT (ssi_disable_cnt=10) -> EN_WAIT, ssi_en falls 1 cycle later then re-rises after ssi_enable_cnt+1 cycles; no done.
REQ-034 rst pulsed while channels 0..3 in ACTIVE with NUM_CH=4 -> all enable/ssi_en low asynchronously; restart after release with tdd_en held.
REQ-035 CNT_W=8, ssi_enable_cnt=255 -> ssi_en rises exactly 256 cycles after enable; channels 1..3 with different counts run concurrently without cross-effect.
